// File: rtl/updown_mod_counter_pkg.sv
// counter_pkg: shared constants and next-count arithmetic for updown_mod_counter
package counter_pkg;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_PRESC_W = 8;
  typedef struct packed {
    logic wrap;
    logic [31:0] cnt;
  } step_t;
  // Count above the modulus (modulus lowered at run time) snaps to the modulus
  // when counting down and wraps to zero when counting up.
  function automatic step_t next_count(input logic up, input logic [31:0] cnt, input logic [31:0] md);
    next_count.wrap = up ? cnt >= md : cnt == 0;
    next_count.cnt = up ? (cnt >= md ? 32'd0 : cnt + 32'd1) : ((cnt == 0 || cnt > md) ? md : cnt - 32'd1);
  endfunction
endpackage

// File: rtl/updown_mod_counter_if.sv
// updown_mod_counter_if: control/status bundle for updown_mod_counter
// master drives EN, UP, LOAD, LOAD_VAL, MOD_VAL, WRAP_CLR (and PRESC_DIV when
// COUNTER_PRESCALE_EN is defined); slave drives COUNT, TC, WRAPPED.
interface updown_mod_counter_if import counter_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int PRESC_W = DEF_PRESC_W
);
  logic EN;
  logic UP;
  logic LOAD;
  logic [WIDTH-1:0] LOAD_VAL;
  logic [WIDTH-1:0] MOD_VAL;
  logic WRAP_CLR;
  logic [WIDTH-1:0] COUNT;
  logic TC;
  logic WRAPPED;
`ifdef COUNTER_PRESCALE_EN
  logic [PRESC_W-1:0] PRESC_DIV;
`endif
  modport master (
`ifdef COUNTER_PRESCALE_EN
    output PRESC_DIV,
`endif
    output EN, UP, LOAD, LOAD_VAL, MOD_VAL, WRAP_CLR,
    input COUNT, TC, WRAPPED
  );
  modport slave (
`ifdef COUNTER_PRESCALE_EN
    input PRESC_DIV,
`endif
    input EN, UP, LOAD, LOAD_VAL, MOD_VAL, WRAP_CLR,
    output COUNT, TC, WRAPPED
  );
endinterface

// File: rtl/updown_mod_counter_prescaler.sv
// counter_prescaler: divides enabled cycles, TICK on the EN cycle where the count equals PRESC_DIV
// Ports: CLK clock, CLR sync active-low reset, EN advance, CLR_P sync clear,
// PRESC_DIV divide value, TICK step strobe (combinational).
module counter_prescaler #(
  parameter int PRESC_W = 8
) (
  input  logic CLK,
  input  logic CLR,
  input  logic EN,
  input  logic CLR_P,
  input  logic [PRESC_W-1:0] PRESC_DIV,
  output logic TICK
);
  logic [PRESC_W-1:0] cnt;
  assign TICK = EN && cnt == PRESC_DIV;
  always_ff @(posedge CLK)
    if (!CLR || CLR_P) cnt <= '0;
    else if (EN) cnt <= TICK ? '0 : cnt + 1'b1;
endmodule

// File: rtl/updown_mod_counter.sv
// updown_mod_counter: up/down modulo counter with load, terminal-count pulse and sticky wrap flag
// Ports: CLK clock, CLR sync active-low reset, bus (updown_mod_counter_if.slave).
// Optional prescaler enabled by defining COUNTER_PRESCALE_EN.
module updown_mod_counter import counter_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int unsigned RESET_VAL = 0,
  parameter int PRESC_W = DEF_PRESC_W
) (
  input logic CLK,
  input logic CLR,
  updown_mod_counter_if.slave bus
);
  if (WIDTH < 2 || WIDTH > 32 || PRESC_W < 1) begin : g_bad
    $error("updown_mod_counter: illegal parameters");
  end
  logic [WIDTH-1:0] count;
  logic tc;
  logic wrapped;
  logic step;
  step_t nxt;
`ifdef COUNTER_PRESCALE_EN
  counter_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .CLK(CLK),
    .CLR(CLR),
    .EN(bus.EN),
    .CLR_P(bus.LOAD),
    .PRESC_DIV(bus.PRESC_DIV),
    .TICK(step)
  );
`else
  assign step = bus.EN;
`endif
  assign nxt = next_count(bus.UP == DIR_UP, 32'(count), 32'(bus.MOD_VAL));
  always_ff @(posedge CLK)
    if (!CLR) begin
      count <= WIDTH'(RESET_VAL);
      tc <= 1'b0;
      wrapped <= 1'b0;
    end else if (bus.LOAD) begin
      count <= bus.LOAD_VAL > bus.MOD_VAL ? bus.MOD_VAL : bus.LOAD_VAL;
      tc <= 1'b0;
    end else begin
      if (step) count <= nxt.cnt[WIDTH-1:0];
      tc <= step && nxt.wrap;
      wrapped <= (step && nxt.wrap) || (wrapped && !bus.WRAP_CLR);
    end
  assign bus.COUNT = count;
  assign bus.TC = tc;
  assign bus.WRAPPED = wrapped;
endmodule
